// File: rtl/vr_serial_if.sv
// Handshake bundle for vr_serial: LLR input, check-message input, extrinsic output.
// The slave modport is the processor's view; master is the surrounding fabric.
interface vr_serial_if #(
  parameter int DATA_WIDTH = 16
);
  logic                         llr_valid;
  logic                         llr_ready;
  logic signed [DATA_WIDTH-1:0] llr;
  logic                         in_valid;
  logic                         in_ready;
  logic signed [DATA_WIDTH-1:0] ch_msg;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [DATA_WIDTH-1:0] vr_msg;
  logic                         out_last;

  modport master (
    output llr_valid, llr, in_valid, ch_msg, out_ready,
    input  llr_ready, in_ready, out_valid, vr_msg, out_last
  );

  modport slave (
    input  llr_valid, llr, in_valid, ch_msg, out_ready,
    output llr_ready, in_ready, out_valid, vr_msg, out_last
  );
endinterface

// File: rtl/vr_serial.sv
// Serial LDPC variable-node processor: LLR plus DEG check messages in, DEG extrinsic messages out.
// Output reduction wraps by default; define VR_SAT_EN to saturate vr_msg and belief instead.
module vr_serial #(
  parameter int INT        = 8,
  parameter int FRAC       = 8,
  parameter int DATA_WIDTH = 16,
  parameter int DEG        = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  vr_serial_if.slave                   bus,
  output logic signed [DATA_WIDTH-1:0] belief,
  output logic                         belief_valid,
  output logic                         hard_bit,
  output logic                         busy
);
  localparam int ACC_W = DATA_WIDTH + $clog2(DEG + 1);
  localparam int CW    = $clog2(DEG);
  localparam logic [CW-1:0] LAST = CW'(DEG - 1);

  if (DATA_WIDTH != INT + FRAC || DEG < 2) begin : g_param_chk
    $error("vr_serial: DATA_WIDTH must equal INT+FRAC and DEG must be >= 2");
  end

  typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;

  state_t                        state, state_nxt;
  logic signed [ACC_W-1:0]       acc;
  logic signed [DATA_WIDTH-1:0]  msg_buf [DEG];
  logic [CW-1:0]                 cnt, idx, idx_inc;
  logic signed [DATA_WIDTH-1:0]  vr_msg_q;
  logic                          out_last_q;
  logic                          llr_acc, msg_acc, out_acc;
  logic signed [ACC_W-1:0]       acc_sum;
  logic signed [DATA_WIDTH-1:0]  belief_nxt, first_ext, next_ext;

  function automatic logic signed [DATA_WIDTH-1:0] reduce(input logic signed [ACC_W-1:0] v);
`ifdef VR_SAT_EN
    // In range only when every bit above the output sign bit matches the full-width sign
    if (v[ACC_W-1:DATA_WIDTH-1] == {(ACC_W-DATA_WIDTH+1){v[ACC_W-1]}})
      return v[DATA_WIDTH-1:0];
    else if (v[ACC_W-1])
      return {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else
      return {1'b0, {(DATA_WIDTH-1){1'b1}}};
`else
    return v[DATA_WIDTH-1:0];
`endif
  endfunction

  always_comb begin
    state_nxt     = state;
    bus.llr_ready = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    busy          = (state != IDLE);
    case (state)
      IDLE: begin
        bus.llr_ready = !rst;
        if (bus.llr_valid && !rst) state_nxt = ACCUM;
      end
      ACCUM: begin
        bus.in_ready = !rst;
        if (bus.in_valid && cnt == LAST) state_nxt = EMIT;
      end
      EMIT: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready && out_last_q) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign llr_acc = bus.llr_valid && bus.llr_ready;
  assign msg_acc = bus.in_valid && bus.in_ready;
  assign out_acc = bus.out_valid && bus.out_ready;

  // Extrinsic = llr + other DEG-1 messages, so it always fits in ACC_W exactly
  assign acc_sum    = acc + ACC_W'(bus.ch_msg);
  assign idx_inc    = idx + CW'(1);
  assign belief_nxt = reduce(acc_sum);
  assign first_ext  = reduce(acc_sum - ACC_W'(msg_buf[0]));
  assign next_ext   = reduce(acc - ACC_W'(msg_buf[idx_inc]));

  assign bus.vr_msg   = vr_msg_q;
  assign bus.out_last = out_last_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc          <= '0;
      cnt          <= '0;
      idx          <= '0;
      vr_msg_q     <= '0;
      out_last_q   <= 1'b0;
      belief       <= '0;
      belief_valid <= 1'b0;
      hard_bit     <= 1'b0;
      for (int i = 0; i < DEG; i++) msg_buf[i] <= '0;
    end else begin
      belief_valid <= 1'b0;
      if (llr_acc) begin
        acc <= ACC_W'(bus.llr);
        cnt <= '0;
      end
      if (msg_acc) begin
        msg_buf[cnt] <= bus.ch_msg;
        acc          <= acc_sum;
        cnt          <= cnt + CW'(1);
        if (cnt == LAST) begin
          belief       <= belief_nxt;
          hard_bit     <= belief_nxt[DATA_WIDTH-1];
          belief_valid <= 1'b1;
          idx          <= '0;
          vr_msg_q     <= first_ext;
          out_last_q   <= 1'b0;
        end
      end
      if (out_acc) begin
        if (out_last_q) begin
          vr_msg_q   <= '0;
          out_last_q <= 1'b0;
        end else begin
          idx        <= idx_inc;
          vr_msg_q   <= next_ext;
          out_last_q <= (idx_inc == LAST);
        end
      end
    end
  end
endmodule

// File: tb/tb_vr_serial.sv
// Bench for vr_serial (DEG=3, 16-bit): spec vectors, backpressure/gap/reset/back-to-back
// sequences, then random passes against an arithmetic reference model.
module tb_vr_serial;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst;
  logic signed [DW-1:0] belief;
  logic belief_valid, hard_bit, busy;

  vr_serial_if #(.DATA_WIDTH(DW)) bus ();

  vr_serial #(.INT(8), .FRAC(8), .DATA_WIDTH(DW), .DEG(3)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .belief(belief), .belief_valid(belief_valid), .hard_bit(hard_bit), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit pre_acc = 1'b0;

  typedef struct {
    logic [15:0] l, m0, m1, m2, eb;
    logic        ehb;
    logic [15:0] e0, e1, e2;
  } vec_t;
  vec_t vt[6];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic longint sx(input logic [15:0] x);
    return longint'($signed(x));
  endfunction

  function automatic logic [15:0] red(input longint v);
`ifdef VR_SAT_EN
    if (v > 32767) return 16'h7FFF;
    if (v < -32768) return 16'h8000;
`endif
    return 16'(v);
  endfunction

  task automatic model(input logic [15:0] l, m0, m1, m2, output logic [15:0] eb,
                       output logic ehb, output logic [15:0] e0, e1, e2);
    longint s;
    s   = sx(l) + sx(m0) + sx(m1) + sx(m2);
    eb  = red(s);
    ehb = eb[15];
    e0  = red(s - sx(m0));
    e1  = red(s - sx(m1));
    e2  = red(s - sx(m2));
  endtask

  function automatic logic [15:0] rnd16();
    if ($urandom_range(1) == 1) return 16'($urandom);
    return 16'($urandom_range(4095)) - 16'd2048;
  endfunction

  // One full pass driven at negedges; handshakes are decided against the readies seen there.
  task automatic run_pass(input string nm, input logic [15:0] l, m0, m1, m2,
                          input logic [15:0] eb, input logic ehb, input logic [15:0] e0, e1, e2,
                          input int gap_pct, input int stall_pct, input int stall_idx,
                          input bit hold, input logic [15:0] next_l, input bit chk_t);
    logic [15:0] msg[3];
    logic [15:0] ev[3];
    logic [15:0] held;
    int cyc, n0, sent, got, bv_cnt, first_out, last_hs, stalled;
    bit llr_done, held_vld;
    msg = '{m0, m1, m2};
    ev  = '{e0, e1, e2};
    cyc = 0; n0 = 0; sent = 0; got = 0; bv_cnt = 0;
    first_out = -1; last_hs = -1; stalled = 0; held_vld = 1'b0; held = '0;
    llr_done = pre_acc;
    pre_acc  = 1'b0;
    bus.llr  = l;
    while (got < 3 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (belief_valid) begin
        bv_cnt++;
        chk({nm, "_belief"}, belief, eb);
        chk({nm, "_hard_bit"}, 16'(hard_bit), 16'(ehb));
        chk({nm, "_bv_first_emit"}, 16'(bus.out_valid && first_out < 0), 16'd1);
      end
      if (held_vld) begin
        chk({nm, "_stall_valid"}, 16'(bus.out_valid), 16'd1);
        chk({nm, "_stall_msg"}, bus.vr_msg, held);
      end
      if (busy) chk({nm, "_llr_rdy_busy"}, 16'(bus.llr_ready), 16'd0);
      if (bus.out_valid) chk({nm, "_in_rdy_emit"}, 16'(bus.in_ready), 16'd0);

      bus.llr_valid = !llr_done || hold;
      bus.in_valid  = (llr_done && sent < 3 && $urandom_range(99) >= gap_pct) ||
                      (hold && bus.out_valid);
      bus.ch_msg    = (sent < 3) ? msg[sent] : 16'hDEAD;
      if (stall_idx == got && stalled < 3 && bus.out_valid) begin
        bus.out_ready = 1'b0;
        stalled++;
      end else begin
        bus.out_ready = $urandom_range(99) >= stall_pct;
      end

      held_vld = 1'b0;
      if (bus.llr_valid && bus.llr_ready) begin
        chk({nm, "_llr_once"}, 16'(llr_done), 16'd0);
        llr_done = 1'b1;
        n0 = cyc;
      end
      if (bus.in_valid && bus.in_ready) begin
        chk({nm, "_in_accept_legal"}, 16'(sent < 3), 16'd1);
        sent++;
      end
      if (bus.out_valid) begin
        chk($sformatf("%s_vr_msg%0d", nm, got), bus.vr_msg, ev[got]);
        chk($sformatf("%s_out_last%0d", nm, got), 16'(bus.out_last), 16'(got == 2));
        if (first_out < 0) first_out = cyc;
        if (bus.out_ready) begin
          got++;
          last_hs = cyc;
        end else begin
          held = bus.vr_msg;
          held_vld = 1'b1;
        end
      end
    end
    chk({nm, "_complete"}, 16'(got), 16'd3);
    if (hold) bus.llr = next_l;
    bus.in_valid  = 1'b0;
    bus.llr_valid = hold;
    @(negedge clk);
    chk({nm, "_end_llr_rdy"}, 16'(bus.llr_ready), 16'd1);
    chk({nm, "_end_busy"}, 16'(busy), 16'd0);
    chk({nm, "_end_out_valid"}, 16'(bus.out_valid), 16'd0);
    chk({nm, "_belief_held"}, belief, eb);
    chk({nm, "_bv_pulses"}, 16'(bv_cnt), 16'd1);
    if (chk_t) begin
      chk({nm, "_first_out_lat"}, 16'(first_out - n0), 16'd4);
      chk({nm, "_last_out_lat"}, 16'(last_hs - n0), 16'd6);
    end
    if (hold && bus.llr_ready) pre_acc = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rl[40], r0[40], r1[40], r2[40];
    logic [15:0] eb, e0, e1, e2;
    logic ehb;

    vt[0] = '{16'h0100, 16'h0080, 16'hFF00, 16'h0200, 16'h0280, 1'b0, 16'h0200, 16'h0380, 16'h0080};
    vt[3] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0000};
    vt[4] = '{16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'hFFFF, 16'h0000, 16'h0000};
`ifdef VR_SAT_EN
    vt[1] = '{16'h7000, 16'h7000, 16'h7000, 16'h7000, 16'h7FFF, 1'b0, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    vt[2] = '{16'h9000, 16'h9000, 16'h9000, 16'h9000, 16'h8000, 1'b1, 16'h8000, 16'h8000, 16'h8000};
    vt[5] = '{16'h8000, 16'h8000, 16'h0000, 16'h7FFF, 16'h8000, 1'b1, 16'hFFFF, 16'h8000, 16'h8000};
`else
    vt[1] = '{16'h7000, 16'h7000, 16'h7000, 16'h7000, 16'hC000, 1'b1, 16'h5000, 16'h5000, 16'h5000};
    vt[2] = '{16'h9000, 16'h9000, 16'h9000, 16'h9000, 16'h4000, 1'b0, 16'hB000, 16'hB000, 16'hB000};
    vt[5] = '{16'h8000, 16'h8000, 16'h0000, 16'h7FFF, 16'h7FFF, 1'b0, 16'hFFFF, 16'h7FFF, 16'h0000};
`endif

    rst = 1'b1;
    bus.llr_valid = 1'b0; bus.llr = '0; bus.in_valid = 1'b0; bus.ch_msg = '0; bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_llr_ready", 16'(bus.llr_ready), 16'd0);
    chk("rst_in_ready", 16'(bus.in_ready), 16'd0);
    chk("rst_out_valid", 16'(bus.out_valid), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_belief", belief, 16'd0);
    chk("rst_vr_msg", bus.vr_msg, 16'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_llr_ready", 16'(bus.llr_ready), 16'd1);

    for (int i = 0; i < 6; i++)
      run_pass($sformatf("vec%0d", i), vt[i].l, vt[i].m0, vt[i].m1, vt[i].m2, vt[i].eb, vt[i].ehb,
               vt[i].e0, vt[i].e1, vt[i].e2, 0, 0, -1, 1'b0, 16'h0, 1'b1);

    run_pass("stall_idx1", vt[0].l, vt[0].m0, vt[0].m1, vt[0].m2, vt[0].eb, vt[0].ehb,
             vt[0].e0, vt[0].e1, vt[0].e2, 0, 0, 1, 1'b0, 16'h0, 1'b0);
    run_pass("in_gaps", vt[0].l, vt[0].m0, vt[0].m1, vt[0].m2, vt[0].eb, vt[0].ehb,
             vt[0].e0, vt[0].e1, vt[0].e2, 60, 0, -1, 1'b0, 16'h0, 1'b0);

    // Abort a pass after two messages, then confirm a clean nominal pass
    @(negedge clk); bus.llr_valid = 1'b1; bus.llr = 16'h4000;
    @(negedge clk); bus.llr_valid = 1'b0; bus.in_valid = 1'b1; bus.ch_msg = 16'h1111;
    @(negedge clk); bus.ch_msg = 16'h2222;
    @(negedge clk); bus.in_valid = 1'b0; rst = 1'b1; #1;
    chk("midrst_in_ready", 16'(bus.in_ready), 16'd0);
    chk("midrst_llr_ready", 16'(bus.llr_ready), 16'd0);
    @(negedge clk);
    chk("midrst_busy", 16'(busy), 16'd0);
    chk("midrst_out_valid", 16'(bus.out_valid), 16'd0);
    chk("midrst_belief", belief, 16'd0);
    chk("midrst_bv", 16'(belief_valid), 16'd0);
    chk("midrst_hard_bit", 16'(hard_bit), 16'd0);
    chk("midrst_out_last", 16'(bus.out_last), 16'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_llr_ready_after", 16'(bus.llr_ready), 16'd1);
    run_pass("after_rst", vt[0].l, vt[0].m0, vt[0].m1, vt[0].m2, vt[0].eb, vt[0].ehb,
             vt[0].e0, vt[0].e1, vt[0].e2, 0, 0, -1, 1'b0, 16'h0, 1'b1);

    run_pass("b2b_a", vt[0].l, vt[0].m0, vt[0].m1, vt[0].m2, vt[0].eb, vt[0].ehb,
             vt[0].e0, vt[0].e1, vt[0].e2, 0, 0, -1, 1'b1, vt[1].l, 1'b1);
    chk("b2b_llr_taken", 16'(pre_acc), 16'd1);
    run_pass("b2b_b", vt[1].l, vt[1].m0, vt[1].m1, vt[1].m2, vt[1].eb, vt[1].ehb,
             vt[1].e0, vt[1].e1, vt[1].e2, 0, 0, -1, 1'b0, 16'h0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      rl[i] = rnd16(); r0[i] = rnd16(); r1[i] = rnd16(); r2[i] = rnd16();
    end
    for (int i = 0; i < 40; i++) begin
      bit h;
      h = (i % 3 == 2) && (i < 39);
      model(rl[i], r0[i], r1[i], r2[i], eb, ehb, e0, e1, e2);
      run_pass($sformatf("rnd%0d", i), rl[i], r0[i], r1[i], r2[i], eb, ehb, e0, e1, e2,
               30, 30, -1, h, (i < 39) ? rl[i + 1] : 16'h0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
